// File: rtl/pc_gen.sv
// Program-counter generator: prioritised redirects (trap, branch, return), sequential
// advance, and a circular return-address stack with a sticky underflow flag.
module pc_gen #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            ret,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  localparam int unsigned     PtrW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] IncVal    = XLEN'(INC);
  localparam logic [XLEN-1:0] AlignMask = ~(IncVal - XLEN'(1));
  localparam logic [CntW-1:0] CntMax    = CntW'(RAS_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            underflow_q;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            mem_we;
  logic [PtrW-1:0] mem_waddr;

  logic            active;
  logic            ret_only;
  logic            ret_sel;
  logic [PtrW-1:0] top_idx;

  // Inputs only matter while running with go held high; go low freezes everything.
  assign active   = (state_q == StRun) && go;
  assign ret_only = active && ret && !trap && !branch;
  assign ret_sel  = ret_only && (cnt_q != '0);
  assign top_idx  = wptr_q - PtrW'(1);

  always_comb begin
    pc_d = pc_q;
    if (active) begin
      if (trap) begin
        pc_d = trap_vec & AlignMask;
      end else if (branch) begin
        pc_d = branch_addr & AlignMask;
      end else if (ret_sel) begin
        pc_d = ras_mem[top_idx] & AlignMask;
      end else if (!stall && fetch_ready) begin
        pc_d = pc_q + IncVal;
      end
    end
  end

  // The write pointer always names the slot after the top; when the stack is full that
  // slot holds the oldest entry, so a push there is the circular overwrite.
  always_comb begin
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;
    if (active && ras_push && ret_sel) begin
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (active && ras_push) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + PtrW'(1);
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (ret_sel) begin
      wptr_d = top_idx;
      cnt_d  = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_VECTOR;
      wptr_q      <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= go ? StRun : StIdle;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      if (ret_only && (cnt_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Entry contents carry no reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ras_mem[mem_waddr] <= ras_push_addr;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = (state_q == StRun);
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CntMax);
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0, stall = 1'b0, fetch_ready = 1'b0;
  logic        trap = 1'b0, branch = 1'b0, ret = 1'b0, ras_push = 1'b0;
  logic [31:0] trap_vec = '0, branch_addr = '0, ras_push_addr = '0;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full, ras_underflow;

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .INC         (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .stall        (stall),
    .fetch_ready  (fetch_ready),
    .trap         (trap),
    .trap_vec     (trap_vec),
    .branch       (branch),
    .branch_addr  (branch_addr),
    .ret          (ret),
    .ras_push     (ras_push),
    .ras_push_addr(ras_push_addr),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model: running flag, pc, and the return stack as a plain queue (back = top).
  bit          m_run;
  bit          m_uf;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0;
    m_uf  = 0;
    m_pc  = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    bit sel_ret;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_run && go) begin
      sel_ret = ret && !trap && !branch && (m_ras.size() > 0);
      if (trap) m_pc = trap_vec & ~32'h3;
      else if (branch) m_pc = branch_addr & ~32'h3;
      else if (sel_ret) m_pc = m_ras[$] & ~32'h3;
      else if (!stall && fetch_ready) m_pc = m_pc + 32'd4;
      if (ret && !trap && !branch && m_ras.size() == 0) m_uf = 1;
      if (sel_ret) void'(m_ras.pop_back());
      if (ras_push) begin
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(ras_push_addr);
      end
    end
    m_run = go;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; trap = 0; branch = 0; ret = 0; ras_push = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_valid", 32'(pc_valid), 32'(m_run));
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
      check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
    end
  end

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom;
  endfunction

  initial begin
    model_reset();
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(pc_valid), 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_uf", 32'(ras_underflow), 32'h0);
    @(posedge clk);
    #1;
    reset  = 1;
    chk_en = 1;

    // Sequential fetch from reset
    go = 1; fetch_ready = 1;
    tick();
    check("seq0", pc, 32'h0);
    check("seq0_valid", 32'(pc_valid), 32'h1);
    tick(); check("seq4", pc, 32'h4);
    tick(); check("seq8", pc, 32'h8);
    tick(); check("seq12", pc, 32'hC);
    tick(); check("seq16", pc, 32'h10);

    // Stall holds; branch under stall still redirects with alignment
    stall = 1;
    tick(); check("stall_hold", pc, 32'h10);
    branch = 1; branch_addr = 32'h203;
    tick(); check("branch_align", pc, 32'h200);
    branch = 0;

    // Five pushes into a 4-deep stack, then pops
    for (int i = 0; i < 5; i++) begin
      ras_push = 1; ras_push_addr = 32'h40 + 32'(i) * 32'h10;
      tick();
    end
    ras_push = 0;
    check("ras_full_after_push", 32'(ras_full), 32'h1);
    ret = 1;
    tick(); check("ret1", pc, 32'h80);
    tick(); check("ret2", pc, 32'h70);
    tick(); check("ret3", pc, 32'h60);
    tick(); check("ret4", pc, 32'h50);
    check("ras_empty_after_pops", 32'(ras_empty), 32'h1);
    stall = 0;
    tick(); check("ret_underflow_seq", pc, 32'h54);
    check("underflow_set", 32'(ras_underflow), 32'h1);
    ret = 0;

    // Trap beats branch and ret; stack untouched
    stall = 1; ras_push = 1; ras_push_addr = 32'h300;
    tick();
    ras_push = 0;
    trap = 1; trap_vec = 32'h100; branch = 1; branch_addr = 32'h500; ret = 1;
    tick(); check("trap_prio", pc, 32'h100);
    check("trap_no_pop", 32'(ras_empty), 32'h0);
    trap = 0; branch = 0;
    tick(); check("ret_after_trap", pc, 32'h300);
    ret = 0;

    // Push and pop in the same cycle
    ras_push = 1; ras_push_addr = 32'h900;
    tick();
    ras_push_addr = 32'hA00; ret = 1;
    tick(); check("push_pop_target", pc, 32'h900);
    ras_push = 0;
    tick(); check("push_pop_replaced", pc, 32'hA00);
    ret = 0;

    // Wrap at the top of the address space, then go low
    branch = 1; branch_addr = 32'hFFFF_FFFF;
    tick(); check("near_top", pc, 32'hFFFF_FFFC);
    branch = 0; stall = 0;
    tick(); check("wrap", pc, 32'h0);
    go = 0;
    tick(); check("go_low_hold", pc, 32'h0);
    check("go_low_valid", 32'(pc_valid), 32'h0);

    // Reset mid-branch
    go = 1;
    tick();
    branch = 1; branch_addr = 32'h200; ras_push = 1; ras_push_addr = 32'h44;
    tick(); check("pre_reset_pc", pc, 32'h200);
    branch_addr = 32'h600;
    #2;
    reset = 0;
    model_reset();
    #1;
    check("mid_reset_pc", pc, 32'h0);
    check("mid_reset_valid", 32'(pc_valid), 32'h0);
    check("mid_reset_empty", 32'(ras_empty), 32'h1);
    clear_inputs(); go = 0;
    tick();
    reset = 1;
    go = 1;
    tick(); check("post_reset_first", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      go            = ($urandom_range(19) != 0);
      stall         = ($urandom_range(3) == 0);
      fetch_ready   = ($urandom_range(4) != 0);
      trap          = ($urandom_range(19) == 0);
      branch        = ($urandom_range(9) == 0);
      ret           = ($urandom_range(5) == 0);
      ras_push      = ($urandom_range(4) == 0);
      trap_vec      = rand_addr();
      branch_addr   = rand_addr();
      ras_push_addr = rand_addr();
      if ($urandom_range(399) == 0) begin
        reset = 0;
        model_reset();
        tick();
        reset = 1;
      end else begin
        tick();
      end
    end

    clear_inputs();
    @(posedge clk);
    #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
